sram_bank_array_rw_r: RTL and testbench

//  Banked 1RW+1R word memory built from 2^(ADDRESS_SIZE-9) sky130_sram_2kbyte_1rw1r_32x512_8 macros (flat, no recursion).

---
 rtl/sram_pkg.sv | 13 +
 rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv | 38 +++
 rtl/sram_read_port_mux.sv | 45 ++++
 rtl/sram_bank_array_rw_r.sv | 132 +++++++++++++
 tb/tb_sram_bank_array_rw_r.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and FSM state type for the banked SRAM array
package sram_pkg;

    localparam int MACRO_ADDRESS_SIZE = 9;
    localparam int MACRO_BYTE_COUNT   = 4;
    localparam int MACRO_DEPTH        = 512;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv - behavioural 1RW+1R 32x512 macro model, registered reads
module sky130_sram_2kbyte_1rw1r_32x512_8 (
`ifdef USE_POWER_PINS
    inout  wire         vccd1,
    inout  wire         vssd1,
`endif
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);

    logic [31:0] r_mem [512];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask0[i]) r_mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                end
            end else begin
                dout0 <= r_mem[addr0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= r_mem[addr1];
    end

endmodule

// File: rtl/sram_read_port_mux.sv
// rtl/sram_read_port_mux.sv - per-port registered bank select, read-valid flop and read-data hold register
module sram_read_port_mux #(
    parameter int BANK_COUNT = 4,
    parameter int BANK_W     = 2,
    parameter int DW         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_accept,
    input  logic [BANK_W-1:0] i_bank,
    input  logic [DW-1:0]     i_bank_dout [BANK_COUNT],
    output logic              o_valid,
    output logic [DW-1:0]     o_data
);

    logic              r_valid;
    logic [BANK_W-1:0] r_bank;
    logic [DW-1:0]     r_hold;
    logic [DW-1:0]     w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_bank  <= '0;
            r_hold  <= '0;
        end else begin
            r_valid <= i_accept;
            if (i_accept) r_bank <= i_bank;
            if (r_valid)  r_hold <= w_sel;
        end
    end

    // Mux on the bank captured with the request, not on the live address.
    generate
        if (BANK_COUNT > 1) begin : g_multi
            assign w_sel = i_bank_dout[r_bank];
        end else begin : g_single
            assign w_sel = i_bank_dout[0];
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_data  = r_valid ? w_sel : r_hold;

endmodule

// File: rtl/sram_bank_array_rw_r.sv
// rtl/sram_bank_array_rw_r.sv - banked 1RW+1R memory with zero-fill FSM; option macro SRAM_COLLISION_STALL_EN
module sram_bank_array_rw_r
    import sram_pkg::*;
#(
    parameter int BYTE_COUNT   = 4,
    parameter int ADDRESS_SIZE = 11
) (
`ifdef USE_POWER_PINS
    inout  wire                      VPWR,
    inout  wire                      VGND,
`endif
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     primarySelect,
    input  logic                     primaryWriteEnable,
    input  logic [BYTE_COUNT-1:0]    primaryWriteMask,
    input  logic [ADDRESS_SIZE-1:0]  primaryAddress,
    input  logic [8*BYTE_COUNT-1:0]  primaryDataWrite,
    output logic                     primaryReady,
    output logic                     primaryReadValid,
    output logic [8*BYTE_COUNT-1:0]  primaryDataRead,
    input  logic                     secondarySelect,
    input  logic [ADDRESS_SIZE-1:0]  secondaryAddress,
    output logic                     secondaryReady,
    output logic                     secondaryReadValid,
    output logic [8*BYTE_COUNT-1:0]  secondaryDataRead,
    output logic                     initDone
);

    localparam int BANK_COUNT = 1 << (ADDRESS_SIZE - MACRO_ADDRESS_SIZE);
    localparam int BANK_W     = (ADDRESS_SIZE > MACRO_ADDRESS_SIZE) ? ADDRESS_SIZE - MACRO_ADDRESS_SIZE : 1;
    localparam int DW         = 8 * BYTE_COUNT;

    state_t            r_state, w_next_state;
    logic [8:0]        r_init_cnt;
    logic              w_init, w_run;
    logic              w_collision;
    logic              w_p_accept, w_s_accept, w_p_rd_accept;
    logic [BANK_W-1:0] w_p_bank, w_s_bank;
    logic [DW-1:0]     w_dout0 [BANK_COUNT];
    logic [DW-1:0]     w_dout1 [BANK_COUNT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= INIT;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == INIT && r_init_cnt == 9'(MACRO_DEPTH - 1)) w_next_state = READY;
    end

    always_comb begin
        w_init = (r_state == INIT);
        w_run  = (r_state == READY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_init_cnt <= '0;
        else if (w_init) r_init_cnt <= r_init_cnt + 9'd1;
    end

`ifdef SRAM_COLLISION_STALL_EN
    assign w_collision = primarySelect && primaryWriteEnable && secondarySelect &&
                         (primaryAddress == secondaryAddress);
`else
    assign w_collision = 1'b0;
`endif

    assign primaryReady   = w_run;
    assign secondaryReady = w_run && !w_collision;
    assign initDone       = w_run;
    assign w_p_accept     = primarySelect && primaryReady;
    assign w_s_accept     = secondarySelect && secondaryReady;
    assign w_p_rd_accept  = w_p_accept && !primaryWriteEnable;

    generate
        if (ADDRESS_SIZE > MACRO_ADDRESS_SIZE) begin : g_bank_sel
            assign w_p_bank = primaryAddress[ADDRESS_SIZE-1:MACRO_ADDRESS_SIZE];
            assign w_s_bank = secondaryAddress[ADDRESS_SIZE-1:MACRO_ADDRESS_SIZE];
        end else begin : g_no_bank_sel
            assign w_p_bank = '0;
            assign w_s_bank = '0;
        end
    endgenerate

    // During INIT every bank writes zero at the same row, so the fill takes one macro depth.
    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic w_csb0, w_csb1;
        assign w_csb0 = w_init ? 1'b0 : !(w_p_accept && w_p_bank == BANK_W'(b));
        assign w_csb1 = !(w_s_accept && w_s_bank == BANK_W'(b));

        sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
`ifdef USE_POWER_PINS
            .vccd1  (VPWR),
            .vssd1  (VGND),
`endif
            .clk0   (clk),
            .csb0   (w_csb0),
            .web0   (w_init ? 1'b0 : !primaryWriteEnable),
            .wmask0 (w_init ? {MACRO_BYTE_COUNT{1'b1}} : primaryWriteMask),
            .addr0  (w_init ? r_init_cnt : primaryAddress[MACRO_ADDRESS_SIZE-1:0]),
            .din0   (w_init ? {DW{1'b0}} : primaryDataWrite),
            .dout0  (w_dout0[b]),
            .clk1   (clk),
            .csb1   (w_csb1),
            .addr1  (secondaryAddress[MACRO_ADDRESS_SIZE-1:0]),
            .dout1  (w_dout1[b])
        );
    end

    sram_read_port_mux #(.BANK_COUNT(BANK_COUNT), .BANK_W(BANK_W), .DW(DW)) u_primary_mux (
        .clk         (clk),
        .rst_n       (rst),
        .i_accept    (w_p_rd_accept),
        .i_bank      (w_p_bank),
        .i_bank_dout (w_dout0),
        .o_valid     (primaryReadValid),
        .o_data      (primaryDataRead)
    );

    sram_read_port_mux #(.BANK_COUNT(BANK_COUNT), .BANK_W(BANK_W), .DW(DW)) u_secondary_mux (
        .clk         (clk),
        .rst_n       (rst),
        .i_accept    (w_s_accept),
        .i_bank      (w_s_bank),
        .i_bank_dout (w_dout1),
        .o_valid     (secondaryReadValid),
        .o_data      (secondaryDataRead)
    );

endmodule

// File: tb/tb_sram_bank_array_rw_r.sv
// tb/tb_sram_bank_array_rw_r.sv - directed self-checking bench for sram_bank_array_rw_r
module tb_sram_bank_array_rw_r;

    logic        clk = 1'b0;
    logic        rst;
    logic        primarySelect, primaryWriteEnable;
    logic [3:0]  primaryWriteMask;
    logic [10:0] primaryAddress;
    logic [31:0] primaryDataWrite;
    logic        primaryReady, primaryReadValid;
    logic [31:0] primaryDataRead;
    logic        secondarySelect;
    logic [10:0] secondaryAddress;
    logic        secondaryReady, secondaryReadValid;
    logic [31:0] secondaryDataRead;
    logic        initDone;

    int n_checks = 0;
    int n_fail   = 0;
    int cycles;

    always #5 clk = ~clk;

    sram_bank_array_rw_r #(.BYTE_COUNT(4), .ADDRESS_SIZE(11)) dut (
        .clk                (clk),
        .rst                (rst),
        .primarySelect      (primarySelect),
        .primaryWriteEnable (primaryWriteEnable),
        .primaryWriteMask   (primaryWriteMask),
        .primaryAddress     (primaryAddress),
        .primaryDataWrite   (primaryDataWrite),
        .primaryReady       (primaryReady),
        .primaryReadValid   (primaryReadValid),
        .primaryDataRead    (primaryDataRead),
        .secondarySelect    (secondarySelect),
        .secondaryAddress   (secondaryAddress),
        .secondaryReady     (secondaryReady),
        .secondaryReadValid (secondaryReadValid),
        .secondaryDataRead  (secondaryDataRead),
        .initDone           (initDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (n < 600) begin
            @(posedge clk);
            #1;
            n++;
            if (initDone) break;
        end
    endtask

    task automatic p_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        primarySelect = 1'b1; primaryWriteEnable = 1'b1;
        primaryAddress = a; primaryDataWrite = d; primaryWriteMask = m;
        @(negedge clk);
        primarySelect = 1'b0; primaryWriteEnable = 1'b0;
    endtask

    task automatic p_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
        @(negedge clk);
        primarySelect = 1'b1; primaryWriteEnable = 1'b0; primaryAddress = a;
        @(negedge clk);
        primarySelect = 1'b0;
        check({tag, "_valid"}, {31'd0, primaryReadValid}, 32'd1);
        check({tag, "_data"}, primaryDataRead, exp);
    endtask

    initial begin
        rst = 1'b0;
        primarySelect = 1'b0; primaryWriteEnable = 1'b0; primaryWriteMask = 4'h0;
        primaryAddress = '0; primaryDataWrite = '0;
        secondarySelect = 1'b0; secondaryAddress = '0;
        repeat (3) @(negedge clk);
        check("rst_init_done", {31'd0, initDone}, 32'd0);
        check("rst_p_ready", {31'd0, primaryReady}, 32'd0);
        check("rst_s_ready", {31'd0, secondaryReady}, 32'd0);
        check("rst_p_valid", {31'd0, primaryReadValid}, 32'd0);
        check("rst_p_data", primaryDataRead, 32'h0);
        check("rst_s_data", secondaryDataRead, 32'h0);

        rst = 1'b1;
        wait_init(cycles);
        check("init_cycles", cycles, 512);
        check("ready_p", {31'd0, primaryReady}, 32'd1);

        p_read("zero_000", 11'h000, 32'h0);
        p_read("zero_7ff", 11'h7FF, 32'h0);
        p_read("zero_3a5", 11'h3A5, 32'h0);

        p_write(11'h000, 32'hDEADBEEF, 4'hF);
        p_write(11'h600, 32'h12345678, 4'hF);
        check("wr_no_valid", {31'd0, primaryReadValid}, 32'd0);
        check("wr_hold_data", primaryDataRead, 32'h0);

        @(negedge clk);
        primarySelect = 1'b1; primaryAddress = 11'h600;
        @(negedge clk);
        primaryAddress = 11'h000;
        check("b2b_v0", {31'd0, primaryReadValid}, 32'd1);
        check("b2b_d0", primaryDataRead, 32'h12345678);
        @(negedge clk);
        primarySelect = 1'b0;
        check("b2b_v1", {31'd0, primaryReadValid}, 32'd1);
        check("b2b_d1", primaryDataRead, 32'hDEADBEEF);
        @(negedge clk);
        check("hold_v", {31'd0, primaryReadValid}, 32'd0);
        check("hold_d", primaryDataRead, 32'hDEADBEEF);

        p_write(11'h205, 32'h11223344, 4'hF);
        p_write(11'h205, 32'hFFFFFFFF, 4'b0010);
        p_read("mask", 11'h205, 32'h1122FF44);

        p_write(11'h0A0, 32'hA0A0A0A0, 4'hF);
        p_write(11'h4A0, 32'h4A4A4A4A, 4'hF);
        p_write(11'h0A1, 32'h0A1A0A1A, 4'hF);
        @(negedge clk);
        primarySelect = 1'b1; primaryAddress = 11'h0A0;
        secondarySelect = 1'b1; secondaryAddress = 11'h4A0;
        @(negedge clk);
        primaryAddress = 11'h0A1; secondaryAddress = 11'h0A0;
        check("dual_p_v", {31'd0, primaryReadValid}, 32'd1);
        check("dual_p_d", primaryDataRead, 32'hA0A0A0A0);
        check("dual_s_v", {31'd0, secondaryReadValid}, 32'd1);
        check("dual_s_d", secondaryDataRead, 32'h4A4A4A4A);
        @(negedge clk);
        primarySelect = 1'b0; secondarySelect = 1'b0;
        check("same_bank_p", primaryDataRead, 32'h0A1A0A1A);
        check("same_bank_s", secondaryDataRead, 32'hA0A0A0A0);
        @(negedge clk);
        check("s_hold_v", {31'd0, secondaryReadValid}, 32'd0);
        check("s_hold_d", secondaryDataRead, 32'hA0A0A0A0);

        @(negedge clk);
        primarySelect = 1'b1; primaryWriteEnable = 1'b1; primaryWriteMask = 4'hF;
        primaryAddress = 11'h010; primaryDataWrite = 32'hCAFEF00D;
        secondarySelect = 1'b1; secondaryAddress = 11'h010;
        #1;
`ifdef SRAM_COLLISION_STALL_EN
        check("coll_s_ready", {31'd0, secondaryReady}, 32'd0);
        @(negedge clk);
        primarySelect = 1'b0; primaryWriteEnable = 1'b0;
        check("coll_s_novalid", {31'd0, secondaryReadValid}, 32'd0);
        check("retry_s_ready", {31'd0, secondaryReady}, 32'd1);
        @(negedge clk);
        secondarySelect = 1'b0;
        check("retry_s_valid", {31'd0, secondaryReadValid}, 32'd1);
        check("retry_s_data", secondaryDataRead, 32'hCAFEF00D);
`else
        check("coll_s_ready", {31'd0, secondaryReady}, 32'd1);
        @(negedge clk);
        primarySelect = 1'b0; primaryWriteEnable = 1'b0; secondarySelect = 1'b0;
        p_read("coll_p_rb", 11'h010, 32'hCAFEF00D);
`endif

        @(negedge clk);
        primarySelect = 1'b1; primaryAddress = 11'h600;
        secondarySelect = 1'b1; secondaryAddress = 11'h0A0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        primarySelect = 1'b0; secondarySelect = 1'b0;
        #1;
        check("mid_rst_p_valid", {31'd0, primaryReadValid}, 32'd0);
        check("mid_rst_s_valid", {31'd0, secondaryReadValid}, 32'd0);
        check("mid_rst_init", {31'd0, initDone}, 32'd0);
        check("mid_rst_p_data", primaryDataRead, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        wait_init(cycles);
        check("reinit_cycles", cycles, 512);
        p_read("rezero_600", 11'h600, 32'h0);
        p_read("rezero_000", 11'h000, 32'h0);
        p_read("rezero_205", 11'h205, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
